// File: rtl/pc_stack_unit.sv
// ----------------------------------------------------------------------------
// pc_stack_unit
//   Program-counter sequencer with an optional circular return-address stack.
//   Next-PC modes: SEQ (pc+STEP), BRANCH (pc+signed offset), JUMP (target),
//   CALL (push pc+STEP, go to target), RET (pop into pc). Codes 5-7 act as SEQ.
//
//   Build option: define PC_RAS_EN to include the return-address stack.
//   Without it, CALL acts as JUMP, RET acts as SEQ and the stack flags are
//   tied to their empty/no-error values.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (priority over everything)
//   stall      in   1 holds PC, stack contents, occupancy and error flag
//   sel[2:0]   in   next-PC mode
//   offset     in   signed branch displacement (WIDTH)
//   target     in   absolute JUMP/CALL address (WIDTH)
//   pc_count   out  registered current PC
//   pc_plus    out  pc_count + STEP (combinational)
//   ras_full   out  stack holds RAS_DEPTH entries
//   ras_empty  out  stack holds no entries
//   ras_err    out  sticky overflow/underflow flag
// ----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int unsigned           WIDTH        = 16,
    parameter int unsigned           STEP         = 2,
    parameter int unsigned           RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_count,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_CALL   = 3'd3,
        SEL_RET    = 3'd4
    } sel_e;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_next_pc;
    sel_e             w_sel;

    assign w_sel     = sel_e'(sel);
    assign w_pc_plus = r_pc + STEP_W;
    assign pc_count  = r_pc;
    assign pc_plus   = w_pc_plus;

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]    r_wp;      // next write slot; r_wp-1 is top of stack
    logic [CW-1:0]    r_occ;
    logic             r_err;
    logic [PW-1:0]    w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_under;
    logic             w_full;
    logic             w_empty;

    assign w_top   = r_wp - PW'(1);
    assign w_full  = (r_occ == DEPTH_C);
    assign w_empty = (r_occ == '0);

    always_comb begin
        w_next_pc = w_pc_plus;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_under   = 1'b0;
        case (w_sel)
            SEL_BRANCH: w_next_pc = r_pc + offset;
            SEL_JUMP:   w_next_pc = target;
            SEL_CALL: begin
                w_next_pc = target;
                w_push    = 1'b1;
            end
            SEL_RET: begin
                if (!w_empty) begin
                    w_next_pc = r_stack[w_top];
                    w_pop     = 1'b1;
                end else begin
                    w_under = 1'b1;
                end
            end
            default: w_next_pc = w_pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc  <= RESET_VECTOR;
            r_wp  <= '0;
            r_occ <= '0;
            r_err <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_next_pc;
            if (w_push) begin
                // When full, the write slot wraps onto the oldest entry, so
                // advancing the pointer alone implements the overwrite.
                r_wp <= r_wp + PW'(1);
                if (w_full) r_err <= 1'b1;
                else        r_occ <= r_occ + CW'(1);
            end else if (w_pop) begin
                r_wp  <= w_top;
                r_occ <= r_occ - CW'(1);
            end else if (w_under) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack contents are not reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && w_push) begin
            r_stack[r_wp] <= w_pc_plus;
        end
    end

    assign ras_full  = w_full;
    assign ras_empty = w_empty;
    assign ras_err   = r_err;
`else
    always_comb begin
        w_next_pc = w_pc_plus;
        case (w_sel)
            SEL_BRANCH: w_next_pc = r_pc + offset;
            SEL_JUMP:   w_next_pc = target;
            SEL_CALL:   w_next_pc = target;
            default:    w_next_pc = w_pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (!stall) begin
            r_pc <= w_next_pc;
        end
    end

    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    localparam logic [2:0] SEQ = 3'd0, BRA = 3'd1, JMP = 3'd2, CAL = 3'd3, RET = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [15:0] offset = '0;
    logic [15:0] target = '0;
    logic [15:0] pc_count, pc_plus;
    logic        ras_full, ras_empty, ras_err;

    int checks = 0;
    int failures = 0;

    pc_stack_unit #(
        .WIDTH(16), .STEP(2), .RAS_DEPTH(4), .RESET_VECTOR(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .sel(sel),
        .offset(offset), .target(target),
        .pc_count(pc_count), .pc_plus(pc_plus),
        .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [2:0]  sel;
        logic [15:0] off;
        logic [15:0] tgt;
        logic [15:0] exp_pc;
        logic        full;
        logic        empty;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [2:0] sl,
                                input logic [15:0] o, input logic [15:0] t,
                                input logic [15:0] p, input logic f,
                                input logic e, input logic er);
        vec_t v;
        v.rst_n = r; v.stall = s; v.sel = sl; v.off = o; v.tgt = t;
        v.exp_pc = p; v.full = f; v.empty = e; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%04h expected=0x%04h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] sl,
                        input logic [15:0] o, input logic [15:0] t);
        @(negedge clk);
        rst_n = r; stall = s; sel = sl; offset = o; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int idx, input logic [15:0] p,
                               input logic f, input logic e, input logic er);
        chk({tag, "_pc"}, idx, pc_count, p);
        chk({tag, "_pc_plus"}, idx, pc_plus, p + 16'd2);
        chk({tag, "_full"}, idx, 16'(ras_full), RAS ? 16'(f) : 16'd0);
        chk({tag, "_empty"}, idx, 16'(ras_empty), RAS ? 16'(e) : 16'd1);
        chk({tag, "_err"}, idx, 16'(ras_err), RAS ? 16'(er) : 16'd0);
    endtask

    initial begin
        // reset, then SEQ x3
        add(0, 0, SEQ, 0, 0, 16'h0000, 0, 1, 0);
        add(1, 0, SEQ, 0, 0, 16'h0002, 0, 1, 0);
        add(1, 0, SEQ, 0, 0, 16'h0004, 0, 1, 0);
        add(1, 0, SEQ, 0, 0, 16'h0006, 0, 1, 0);
        // negative branch and wrap
        add(1, 0, JMP, 0, 16'h0010, 16'h0010, 0, 1, 0);
        add(1, 0, BRA, 16'hFFF8, 0, 16'h0008, 0, 1, 0);
        add(1, 0, JMP, 0, 16'hFFFE, 16'hFFFE, 0, 1, 0);
        add(1, 0, SEQ, 0, 0, 16'h0000, 0, 1, 0);
        // CALL / SEQ / RET
        add(1, 0, JMP, 0, 16'h0100, 16'h0100, 0, 1, 0);
        add(1, 0, CAL, 0, 16'h0400, 16'h0400, 0, 0, 0);
        add(1, 0, SEQ, 0, 0, 16'h0402, 0, 0, 0);
        add(1, 0, RET, 0, 0, RAS ? 16'h0102 : 16'h0404, 0, 1, 0);
        // five CALLs, five RETs
        add(1, 0, JMP, 0, 16'h0010, 16'h0010, 0, 1, 0);
        add(1, 0, CAL, 0, 16'h0020, 16'h0020, 0, 0, 0);
        add(1, 0, CAL, 0, 16'h0030, 16'h0030, 0, 0, 0);
        add(1, 0, CAL, 0, 16'h0040, 16'h0040, 0, 0, 0);
        add(1, 0, CAL, 0, 16'h0050, 16'h0050, 1, 0, 0);
        add(1, 0, CAL, 0, 16'h0060, 16'h0060, 1, 0, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0052 : 16'h0062, 0, 0, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0042 : 16'h0064, 0, 0, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0032 : 16'h0066, 0, 0, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0022 : 16'h0068, 0, 1, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0024 : 16'h006A, 0, 1, 1);
        // stall holds everything
        add(1, 0, JMP, 0, 16'h0200, 16'h0200, 0, 1, 1);
        add(1, 0, CAL, 0, 16'h0300, 16'h0300, 0, 0, 1);
        add(1, 1, JMP, 0, 16'h0AAA, 16'h0300, 0, 0, 1);
        add(1, 1, JMP, 0, 16'h0AAA, 16'h0300, 0, 0, 1);
        add(1, 1, JMP, 0, 16'h0AAA, 16'h0300, 0, 0, 1);
        add(1, 1, RET, 0, 0, 16'h0300, 0, 0, 1);
        add(1, 0, JMP, 0, 16'h0AAA, 16'h0AAA, 0, 0, 1);
        add(1, 0, RET, 0, 0, RAS ? 16'h0202 : 16'h0AAC, 0, 1, 1);
        // reset mid-sequence, with stall and RET asserted
        add(1, 0, JMP, 0, 16'h0100, 16'h0100, 0, 1, 1);
        add(1, 0, CAL, 0, 16'h0500, 16'h0500, 0, 0, 1);
        add(1, 0, CAL, 0, 16'h0600, 16'h0600, 0, 0, 1);
        add(0, 1, RET, 0, 0, 16'h0000, 0, 1, 0);
        add(1, 0, RET, 0, 0, 16'h0002, 0, 1, 1);
        // reserved codes behave as SEQ
        add(1, 0, 3'd5, 16'h1234, 16'h4321, 16'h0004, 0, 1, 1);
        add(1, 0, 3'd6, 16'h1234, 16'h4321, 16'h0006, 0, 1, 1);
        add(1, 0, 3'd7, 16'h1234, 16'h4321, 16'h0008, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].stall, vecs[i].sel, vecs[i].off, vecs[i].tgt);
            check_state("vec", i, vecs[i].exp_pc, vecs[i].full, vecs[i].empty, vecs[i].err);
        end

        // Circular overwrite: six CALLs into a 4-deep stack; the two oldest
        // return addresses are lost and LIFO order holds for the rest.
        step(0, 0, SEQ, 0, 0);
        check_state("wrap_rst", 0, 16'h0000, 0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, CAL, 0, 16'(k * 16'h1000));
            check_state("wrap_call", k, 16'(k * 16'h1000), k >= 4, 0, k >= 5);
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 0, RET, 0, 0);
            check_state("wrap_ret", k,
                        RAS ? 16'(16'h5002 - k * 16'h1000) : 16'(16'h6002 + 2 * k),
                        0, k == 3, 1);
        end
        step(1, 0, RET, 0, 0);
        check_state("wrap_under", 4, RAS ? 16'h2004 : 16'h600A, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
